// File: rtl/pwm_actuador_pkg.sv
// Shared defaults and helpers for the PWM actuator block.
package pwm_actuador_pkg;

  localparam int CANT_BITS_DEF  = 20;
  localparam int PERIOD_CNT_DEF = 1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } estado_t;

  // Width of a duty value able to hold 0..period inclusive.
  function automatic int cw_of(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_actuador_escala_sat.sv
// Effort-to-duty scaler: |suma| >> SHIFT, deadband, clip to full period.
module escala_sat
  import pwm_actuador_pkg::*;
#(
  parameter int cant_bits  = CANT_BITS_DEF,
  parameter int PERIOD_CNT = PERIOD_CNT_DEF,
  parameter int SHIFT      = 4,
  parameter int DEADBAND   = 0,
  parameter int CW         = cw_of(PERIOD_CNT)
) (
  input  logic [2*cant_bits-1:0] suma,
  output logic [CW-1:0]          duty_nxt,
  output logic                   sat_nxt,
  output logic                   dir_nxt
);

  // One extra bit so the most negative effort has a representable magnitude.
  localparam int MW = 2*cant_bits + 1;
  localparam logic [MW-1:0] PC_MW = MW'(PERIOD_CNT);
  localparam logic [CW-1:0] PC_CW = CW'(PERIOD_CNT);

  logic          neg;
  logic [MW-1:0] ext, absv, mag;
  logic          in_db;

  assign neg  = suma[2*cant_bits-1];
  assign ext  = {neg, suma};
  assign absv = neg ? (~ext + 1'b1) : ext;
  assign mag  = absv >> SHIFT;

  // A zero deadband must not produce an always-false unsigned compare.
  generate
    if (DEADBAND > 0) begin : g_db
      assign in_db = (mag < MW'(DEADBAND));
    end else begin : g_nodb
      assign in_db = 1'b0;
    end
  endgenerate

  // Deadband wins over clipping; direction is only meaningful with nonzero duty.
  always_comb begin
    duty_nxt = '0;
    sat_nxt  = 1'b0;
    dir_nxt  = 1'b0;
    if (in_db) begin
      duty_nxt = '0;
    end else if (mag > PC_MW) begin
      duty_nxt = PC_CW;
      sat_nxt  = 1'b1;
      dir_nxt  = neg;
    end else begin
      duty_nxt = mag[CW-1:0];
      dir_nxt  = neg && (mag != '0);
    end
  end

endmodule

// File: rtl/pwm_actuador.sv
// PWM actuator: period counter, sample strobe, double-buffered duty/dir drive.
module pwm_actuador
  import pwm_actuador_pkg::*;
#(
  parameter int cant_bits  = CANT_BITS_DEF,
  parameter int PERIOD_CNT = PERIOD_CNT_DEF,
  parameter int SHIFT      = 4,
  parameter int DEADBAND   = 0,
  parameter int SAMPLE_DIV = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [2*cant_bits-1:0]      suma,
  output logic                        listo,
  output logic                        pwm,
  output logic                        dir,
  output logic [cw_of(PERIOD_CNT)-1:0] duty,
  output logic                        sat
);

  localparam int CW = cw_of(PERIOD_CNT);
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] P1 = CW'(PERIOD_CNT - 1);
  localparam logic [CW-1:0] P2 = CW'(PERIOD_CNT - 2);
  localparam logic [CW-1:0] P3 = CW'(PERIOD_CNT - 3);
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_DIV - 1);

  estado_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] samp, samp_n;
  logic          go, wrap, samp_last, capture;

  logic [CW-1:0] duty_nxt, sh_duty, duty_n;
  logic          sat_nxt, dir_nxt, sh_sat, sh_dir, sat_n, dir_n;

  escala_sat #(
    .cant_bits (cant_bits),
    .PERIOD_CNT(PERIOD_CNT),
    .SHIFT     (SHIFT),
    .DEADBAND  (DEADBAND),
    .CW        (CW)
  ) u_escala (
    .suma    (suma),
    .duty_nxt(duty_nxt),
    .sat_nxt (sat_nxt),
    .dir_nxt (dir_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state: en alone selects run or idle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (en)  state_n = ST_RUN;
      ST_RUN:  if (!en) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM outputs: counting qualifier and the sample strobe.
  always_comb begin
    go        = (state == ST_RUN) && en;
    wrap      = (cnt == P1);
    samp_last = (samp == SLAST);
    listo     = go && (cnt == P3) && samp_last;
    capture   = go && (cnt == P2) && samp_last;
  end

  // Next counter and active drive values; active only changes at the wrap.
  always_comb begin
    cnt_n  = '0;
    samp_n = '0;
    duty_n = '0;
    dir_n  = 1'b0;
    sat_n  = 1'b0;
    if (go) begin
      cnt_n  = wrap ? '0 : cnt + 1'b1;
      samp_n = wrap ? (samp_last ? '0 : samp + 1'b1) : samp;
      duty_n = wrap ? sh_duty : duty;
      dir_n  = wrap ? sh_dir  : dir;
      sat_n  = wrap ? sh_sat  : sat;
    end
  end

  // Counter, active registers and pwm, registered from next values so pwm lines up with cnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      samp <= '0;
      duty <= '0;
      dir  <= 1'b0;
      sat  <= 1'b0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      samp <= samp_n;
      duty <= duty_n;
      dir  <= dir_n;
      sat  <= sat_n;
      pwm  <= go && (cnt_n < duty_n);
    end
  end

  // Shadow buffer: sampled from suma one cycle after listo, cleared when not running.
  always_ff @(posedge clk) begin
    if (!rst || !go) begin
      sh_duty <= '0;
      sh_dir  <= 1'b0;
      sh_sat  <= 1'b0;
    end else if (capture) begin
      sh_duty <= duty_nxt;
      sh_dir  <= dir_nxt;
      sh_sat  <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_actuador.sv
// Directed bench for pwm_actuador with PERIOD_CNT=100, SHIFT=4.
module tb_pwm_actuador;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [39:0] suma = '0;

  logic       listo_m, pwm_m, dir_m, sat_m;
  logic [6:0] duty_m;
  logic       listo_db, pwm_db, dir_db, sat_db;
  logic [6:0] duty_db;
  logic       listo_sd, pwm_sd, dir_sd, sat_sd;
  logic [6:0] duty_sd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_actuador #(.cant_bits(20), .PERIOD_CNT(100), .SHIFT(4), .DEADBAND(0), .SAMPLE_DIV(1)) u_main (
    .clk(clk), .rst(rst), .en(en), .suma(suma),
    .listo(listo_m), .pwm(pwm_m), .dir(dir_m), .duty(duty_m), .sat(sat_m));

  pwm_actuador #(.cant_bits(20), .PERIOD_CNT(100), .SHIFT(4), .DEADBAND(5), .SAMPLE_DIV(1)) u_db (
    .clk(clk), .rst(rst), .en(en), .suma(suma),
    .listo(listo_db), .pwm(pwm_db), .dir(dir_db), .duty(duty_db), .sat(sat_db));

  pwm_actuador #(.cant_bits(20), .PERIOD_CNT(100), .SHIFT(4), .DEADBAND(0), .SAMPLE_DIV(2)) u_sd (
    .clk(clk), .rst(rst), .en(en), .suma(suma),
    .listo(listo_sd), .pwm(pwm_sd), .dir(dir_sd), .duty(duty_sd), .sat(sat_sd));

  // Advance to the next main listo, then 3 cycles on to cnt=0 of the following period.
  task automatic to_period_start();
    int n = 0;
    while (!listo_m && n < 250) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!listo_m) begin
      errors++;
      $display("FAIL listo_timeout: no strobe within %0d cycles, need one within 250", n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Walk one full period of the main instance; count highs and deviations from a leading block.
  task automatic measure(input int exp_hi, output int hi, output int pe);
    hi = 0;
    pe = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwm_m) hi++;
      if (pwm_m !== (i < exp_hi)) pe++;
      @(negedge clk);
    end
  endtask

  // Count cycles from the current one (cnt=0) up to the main listo.
  task automatic cycles_to_listo(output int n);
    n = 0;
    while (!listo_m && n < 250) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    en   = 1'b1;
    suma = 40'd800;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({listo_m, pwm_m, dir_m, sat_m, duty_m, listo_db, pwm_db, dir_db, sat_db, duty_db,
           listo_sd, pwm_sd, dir_sd, sat_sd, duty_sd} !== '0) begin
        errors++;
        $display("FAIL reset_quiet: cycle %0d duty_m=%0d pwm_m=%b listo_m=%b dir_m=%b sat_m=%b, need all 0",
                 c, duty_m, pwm_m, listo_m, dir_m, sat_m);
      end
    end
  endtask

  task automatic test_duty_pos();
    int n, hi, pe;
    rst = 1'b1;
    @(negedge clk);
    cycles_to_listo(n);
    checks++;
    if (n != 97) begin
      errors++;
      $display("FAIL first_listo: at cycle %0d, need 97", n);
    end
    checks++;
    if (duty_m !== 7'd0) begin
      errors++;
      $display("FAIL first_period_duty: duty=%0d, need 0", duty_m);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({duty_m, dir_m, sat_m} !== {7'd50, 1'b0, 1'b0} || duty_db !== 7'd50) begin
      errors++;
      $display("FAIL pos_duty: duty=%0d dir=%b sat=%b duty_db=%0d, need 50 0 0 50",
               duty_m, dir_m, sat_m, duty_db);
    end
    measure(50, hi, pe);
    checks++;
    if (hi != 50 || pe != 0) begin
      errors++;
      $display("FAIL pos_pwm: highs=%0d misplaced=%0d, need 50 and 0", hi, pe);
    end
    cycles_to_listo(n);
    checks++;
    if (n != 97) begin
      errors++;
      $display("FAIL listo_period: at cnt %0d, need 97", n);
    end
  endtask

  task automatic test_negative();
    int hi, pe;
    suma = -40'sd320;
    to_period_start();
    checks++;
    if ({duty_m, dir_m, sat_m} !== {7'd20, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL neg_duty: duty=%0d dir=%b sat=%b, need 20 1 0", duty_m, dir_m, sat_m);
    end
    measure(20, hi, pe);
    checks++;
    if (hi != 20 || pe != 0) begin
      errors++;
      $display("FAIL neg_pwm: highs=%0d misplaced=%0d, need 20 and 0", hi, pe);
    end
    suma = 40'd8;
    to_period_start();
    checks++;
    if ({duty_m, dir_m, sat_m} !== {7'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL small_duty: duty=%0d dir=%b sat=%b, need 0 0 0", duty_m, dir_m, sat_m);
    end
    measure(0, hi, pe);
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL small_pwm: highs=%0d, need 0", hi);
    end
  endtask

  task automatic test_deadband();
    suma = 40'd64;
    to_period_start();
    checks++;
    if (duty_m !== 7'd4 || duty_db !== 7'd0 || dir_db !== 1'b0) begin
      errors++;
      $display("FAIL deadband: duty_main=%0d duty_db=%0d dir_db=%b, need 4 0 0", duty_m, duty_db, dir_db);
    end
  endtask

  task automatic test_saturation();
    int hi, pe;
    suma = 40'd4000;
    to_period_start();
    checks++;
    if ({duty_m, dir_m, sat_m} !== {7'd100, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_pos: duty=%0d dir=%b sat=%b, need 100 0 1", duty_m, dir_m, sat_m);
    end
    measure(100, hi, pe);
    checks++;
    if (hi != 100 || pe != 0) begin
      errors++;
      $display("FAIL sat_pwm: highs=%0d misplaced=%0d, need 100 and 0", hi, pe);
    end
    suma = 40'h80_0000_0000;
    to_period_start();
    checks++;
    if ({duty_m, dir_m, sat_m} !== {7'd100, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sat_minneg: duty=%0d dir=%b sat=%b, need 100 1 1", duty_m, dir_m, sat_m);
    end
  endtask

  task automatic test_mid_change();
    int bad = 0;
    suma = 40'd800;
    to_period_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 40) suma = -40'sd480;
      if (duty_m !== 7'd50 || pwm_m !== (i < 50)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_change_hold: %0d cycles deviated, need 0", bad);
    end
    checks++;
    if ({duty_m, dir_m} !== {7'd30, 1'b1}) begin
      errors++;
      $display("FAIL mid_change_next: duty=%0d dir=%b, need 30 1", duty_m, dir_m);
    end
  endtask

  task automatic test_idle_and_reset();
    int n, bad;
    suma = 40'd800;
    to_period_start();
    repeat (30) @(negedge clk);
    checks++;
    if (pwm_m !== 1'b1) begin
      errors++;
      $display("FAIL pre_idle_pwm: pwm=%b, need 1", pwm_m);
    end
    en  = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({listo_m, pwm_m, dir_m, sat_m, duty_m} !== '0 || u_main.cnt !== 7'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d idle cycles not quiet, need 0", bad);
    end
    en = 1'b1;
    @(negedge clk);
    cycles_to_listo(n);
    checks++;
    if (n != 97) begin
      errors++;
      $display("FAIL restart_listo: at cycle %0d, need 97", n);
    end
    suma = 40'd1280;
    to_period_start();
    to_period_start();
    checks++;
    if (duty_m !== 7'd80) begin
      errors++;
      $display("FAIL pre_reset_duty: duty=%0d, need 80", duty_m);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (pwm_m !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pwm: pwm=%b, need 1", pwm_m);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({listo_m, pwm_m, dir_m, sat_m, duty_m} !== '0 || u_main.cnt !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: pwm=%b duty=%0d cnt=%0d, need 0 0 0", pwm_m, duty_m, u_main.cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    cycles_to_listo(n);
    checks++;
    if (n != 97) begin
      errors++;
      $display("FAIL post_reset_listo: at cycle %0d, need 97", n);
    end
  endtask

  task automatic test_sample_div();
    int n = 0, nm = 0;
    while (!listo_sd && n < 450) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!listo_sd) begin
      errors++;
      $display("FAIL sd_timeout: no strobe within %0d cycles, need one within 450", n);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (listo_m) nm++;
    end while (!listo_sd && n < 450);
    checks++;
    if (n != 200 || nm != 2) begin
      errors++;
      $display("FAIL sd_gap: gap=%0d main_strobes=%0d, need 200 and 2", n, nm);
    end
    suma = 40'd480;
    repeat (3) @(negedge clk);
    checks++;
    if (duty_m !== 7'd30 || duty_sd !== 7'd30) begin
      errors++;
      $display("FAIL sd_load: duty_main=%0d duty_sd=%0d, need 30 30", duty_m, duty_sd);
    end
    suma = 40'd160;
    repeat (100) @(negedge clk);
    checks++;
    if (duty_m !== 7'd10 || duty_sd !== 7'd30) begin
      errors++;
      $display("FAIL sd_hold: duty_main=%0d duty_sd=%0d, need 10 30", duty_m, duty_sd);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (duty_sd !== 7'd10) begin
      errors++;
      $display("FAIL sd_update: duty_sd=%0d, need 10", duty_sd);
    end
  endtask

  initial begin
    test_reset();
    test_duty_pos();
    test_negative();
    test_deadband();
    test_saturation();
    test_mid_change();
    test_idle_and_reset();
    test_sample_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
